// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: funct3 store codes, drain FSM states
// and the buffered entry layout.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic [31:0] word_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_align.sv
// Lane steering for one store request: funct3 and low address bits to byte
// enables, replicated write data, legality and misalignment flags.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        legal,
  output logic        misaligned
);

  // Decode store width; halfword lane ignores addr_lo[0] so it is force-aligned
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0000_0000;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
        legal = 1'b1;
      end
      F3_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        legal      = 1'b1;
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        be         = 4'b1111;
        wdata      = data;
        legal      = 1'b1;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        legal      = 1'b0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of word-aligned writes drained over
// req/ack, with load-hazard detection. STORE_BUF_ALIGN_CHK_EN rejects misaligned stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [31:0]             st_addr,
  input  logic [31:0]             st_data,
  input  logic [2:0]              st_funct3,
  input  logic                    ld_valid,
  input  logic [31:0]             ld_addr,
  output logic                    ld_hazard,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_ack,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    st_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef STORE_BUF_ALIGN_CHK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  sb_entry_t          entries_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  drain_state_e       state_r;

  logic [3:0]         al_be_s;
  logic [31:0]        al_wdata_s;
  logic               al_legal_s;
  logic               al_mis_s;
  logic               push_s;
  logic               pop_s;
  logic               go_idle_s;
  logic               hit_s;
  sb_entry_t          push_entry_s;
  sb_entry_t          head_entry_s;
  sb_entry_t          next_entry_s;
  logic [PTR_W-1:0]   rd_next_s;
  logic [DEPTH-1:0]   valid_set_s;
  logic [DEPTH-1:0]   valid_clr_s;
  logic               unused_ld_lo_s;

  store_align u_align (
    .funct3     (st_funct3),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .be         (al_be_s),
    .wdata      (al_wdata_s),
    .legal      (al_legal_s),
    .misaligned (al_mis_s)
  );

  assign count     = count_r;
  assign st_ready  = (count_r != CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_s    = st_valid && st_ready && al_legal_s && !(ALIGN_CHK && al_mis_s);
  assign pop_s     = (state_r == REQ) && mem_ack;
  assign go_idle_s = (count_r == CNT_W'(1)) && !push_s;

  assign push_entry_s = '{addr: st_addr[31:2], wdata: al_wdata_s, be: al_be_s};
  assign head_entry_s = entries_r[rd_ptr_r];
  assign rd_next_s    = rd_ptr_r + PTR_W'(1);
  // With a single entry left, the only possible successor is the store arriving this cycle
  assign next_entry_s = (count_r > CNT_W'(1)) ? entries_r[rd_next_s] : push_entry_s;

  assign valid_set_s    = push_s ? (DEPTH'(1) << wr_ptr_r) : DEPTH'(0);
  assign valid_clr_s    = pop_s  ? (DEPTH'(1) << rd_ptr_r) : DEPTH'(0);
  assign unused_ld_lo_s = ^ld_addr[1:0];

  // Word-granular match of the load against buffered and incoming stores
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (entries_r[i].addr == ld_addr[31:2])) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    ld_hazard = ld_valid && (hit_s || (push_s && (st_addr[31:2] == ld_addr[31:2])));
  end

  // Slot storage and per-slot valid flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      valid_r <= '0;
    end else begin
      if (push_s) begin
        entries_r[wr_ptr_r] <= push_entry_s;
      end
      valid_r <= (valid_r & ~valid_clr_s) | valid_set_s;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM with registered memory-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != CNT_W'(0)) begin
            state_r   <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= word_addr(head_entry_s.addr);
            mem_wdata <= head_entry_s.wdata;
            mem_be    <= head_entry_s.be;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (go_idle_s) begin
              state_r <= IDLE;
              mem_req <= 1'b0;
            end else begin
              mem_addr  <= word_addr(next_entry_s.addr);
              mem_wdata <= next_entry_s.wdata;
              mem_be    <= next_entry_s.be;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle error pulse after a rejected misaligned attempt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_err <= 1'b0;
    end else begin
      st_err <= ALIGN_CHK && st_valid && st_ready && al_legal_s && al_mis_s;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; the alignment scenario follows
// the STORE_BUF_ALIGN_CHK_EN build setting.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [2:0]  st_funct3 = 3'b000;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic [2:0]  count;
  logic        st_err;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .empty(empty), .count(count), .st_err(st_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++; if ({mem_req, mem_be, st_ready, empty, st_err} !== 8'b0000_0110) begin
      n_err++; $display("FAIL reset_flags: got %b expected %b", {mem_req, mem_be, st_ready, empty, st_err}, 8'b0000_0110); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    drive_st(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 3'b000);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    n_cmp++; if ({mem_req, count} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL sb_latency: got req=%b cnt=%0d expected req=0 cnt=1", mem_req, count); end
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sb_req: got %b expected 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL sb_addr: got %h expected 00001000", mem_addr); end
    n_cmp++; if (mem_be !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b expected 1000", mem_be); end
    n_cmp++; if (mem_wdata !== 32'hDDDD_DDDD) begin n_err++; $display("FAIL sb_wdata: got %h expected dddddddd", mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, empty} !== 2'b01) begin
      n_err++; $display("FAIL sb_drained: got req=%b empty=%b expected req=0 empty=1", mem_req, empty); end
  endtask

  task automatic test_sh_sw();
    drive_st(1'b1, 32'h0000_2000, 32'h1234_5678, 3'b011);
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL illegal_f3_dropped: got cnt=%0d expected 0", count); end
    drive_st(1'b1, 32'h0000_2002, 32'h1234_5678, 3'b001);
    tick();
    drive_st(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    n_cmp++; if ({mem_req, count, mem_be, mem_addr, mem_wdata} !== {1'b1, 3'd2, 4'b1100, 32'h0000_2000, 32'h5678_5678}) begin
      n_err++; $display("FAIL sh_head: got req=%b cnt=%0d be=%b addr=%h data=%h expected 1 2 1100 00002000 56785678",
                        mem_req, count, mem_be, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    n_cmp++; if ({mem_req, count, mem_be, mem_addr, mem_wdata} !== {1'b1, 3'd1, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL sw_head: got req=%b cnt=%0d be=%b addr=%h data=%h expected 1 1 1111 00003000 cafef00d",
                        mem_req, count, mem_be, mem_addr, mem_wdata); end
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, empty} !== 2'b01) begin
      n_err++; $display("FAIL shsw_drained: got req=%b empty=%b expected 0 1", mem_req, empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 32'h0000_0100 + 32'(4 * i), 32'(i + 1), 3'b010);
      tick();
    end
    n_cmp++; if ({st_ready, count} !== {1'b0, 3'd4}) begin
      n_err++; $display("FAIL full_state: got rdy=%b cnt=%0d expected rdy=0 cnt=4", st_ready, count); end
    drive_st(1'b1, 32'h0000_0110, 32'h5, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    n_cmp++; if ({count, mem_addr} !== {3'd4, 32'h0000_0100}) begin
      n_err++; $display("FAIL full_reject: got cnt=%0d head=%h expected 4 00000100", count, mem_addr); end
    mem_ack = 1'b1;
    tick();
    n_cmp++; if ({st_ready, count, mem_addr, mem_wdata} !== {1'b1, 3'd3, 32'h0000_0104, 32'h2}) begin
      n_err++; $display("FAIL full_first_ack: got rdy=%b cnt=%0d addr=%h data=%h expected 1 3 00000104 00000002",
                        st_ready, count, mem_addr, mem_wdata); end
    for (int i = 2; i < 4; i++) begin
      tick();
      n_cmp++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0100 + 32'(4 * i), 32'(i + 1)}) begin
        n_err++; $display("FAIL full_order_%0d: got req=%b addr=%h data=%h expected 1 %h %h",
                          i, mem_req, mem_addr, mem_wdata, 32'h0000_0100 + 32'(4 * i), 32'(i + 1)); end
    end
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, empty} !== 2'b01) begin
      n_err++; $display("FAIL full_drained: got req=%b empty=%b expected 0 1", mem_req, empty); end
  endtask

  task automatic test_back_to_back();
    drive_st(1'b1, 32'h0000_0200, 32'h100, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin
      n_err++; $display("FAIL b2b_first: got req=%b addr=%h expected 1 00000200", mem_req, mem_addr); end
    mem_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      drive_st(1'b1, 32'h0000_0200 + 32'(4 * i), 32'h100 + 32'(i), 3'b010);
      tick();
      n_cmp++; if ({mem_req, count, mem_addr, mem_wdata} !== {1'b1, 3'd1, 32'h0000_0200 + 32'(4 * i), 32'h100 + 32'(i)}) begin
        n_err++; $display("FAIL b2b_stream_%0d: got req=%b cnt=%0d addr=%h data=%h expected 1 1 %h %h",
                          i, mem_req, count, mem_addr, mem_wdata, 32'h0000_0200 + 32'(4 * i), 32'h100 + 32'(i)); end
    end
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, empty} !== 2'b01) begin
      n_err++; $display("FAIL b2b_drained: got req=%b empty=%b expected 0 1", mem_req, empty); end
  endtask

  task automatic test_hazard_and_reset();
    drive_st(1'b1, 32'h0000_4000, 32'h11, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    ld_valid = 1'b1; ld_addr = 32'h0000_4002; #1;
    n_cmp++; if (ld_hazard !== 1'b1) begin n_err++; $display("FAIL hz_same_word: got %b expected 1", ld_hazard); end
    ld_addr = 32'h0000_4004; #1;
    n_cmp++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL hz_next_word: got %b expected 0", ld_hazard); end
    ld_valid = 1'b0; ld_addr = 32'h0000_4000; #1;
    n_cmp++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL hz_no_load: got %b expected 0", ld_hazard); end
    ld_valid = 1'b1; ld_addr = 32'h0000_400B;
    drive_st(1'b1, 32'h0000_4008, 32'h22, 3'b010); #1;
    n_cmp++; if (ld_hazard !== 1'b1) begin n_err++; $display("FAIL hz_incoming: got %b expected 1", ld_hazard); end
    tick();
    ld_valid = 1'b0;
    drive_st(1'b1, 32'h0000_400C, 32'h33, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
    #2;
    n_cmp++; if ({mem_req, count} !== {1'b1, 3'd3}) begin
      n_err++; $display("FAIL rst_precond: got req=%b cnt=%0d expected 1 3", mem_req, count); end
    rst = 1'b0; #1;
    n_cmp++; if ({mem_req, count, empty, st_ready} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL rst_midflight: got req=%b cnt=%0d empty=%b rdy=%b expected 0 0 1 1",
                        mem_req, count, empty, st_ready); end
    ld_valid = 1'b1; ld_addr = 32'h0000_4000; #1;
    n_cmp++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL rst_hz_cleared: got %b expected 0", ld_hazard); end
    ld_valid = 1'b0;
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_align();
    drive_st(1'b1, 32'h0000_5002, 32'h55, 3'b010);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 3'b000);
`ifdef STORE_BUF_ALIGN_CHK_EN
    n_cmp++; if ({st_err, count} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL align_reject: got err=%b cnt=%0d expected 1 0", st_err, count); end
    tick();
    n_cmp++; if ({st_err, mem_req} !== 2'b00) begin
      n_err++; $display("FAIL align_pulse_end: got err=%b req=%b expected 0 0", st_err, mem_req); end
`else
    n_cmp++; if ({st_err, count} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL align_forced: got err=%b cnt=%0d expected 0 1", st_err, count); end
    tick();
    n_cmp++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h0000_5000, 4'b1111}) begin
      n_err++; $display("FAIL align_forced_out: got req=%b addr=%h be=%b expected 1 00005000 1111", mem_req, mem_addr, mem_be); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_sw();
    test_full();
    test_back_to_back();
    test_hazard_and_reset();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle CPU's store path and data memory. Accepts store requests (address, rs2 data, funct3) from the execute stage, converts them to word-aligned writes with byte enables, queues them in a DEPTH-entry FIFO, and drains them to memory over a req/ack handshake. Lets the core retire stores without waiting on memory. Flags loads that hit a pending store so the core stalls instead of reading stale data.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from CPU
- st_ready  out  1  buffer can accept (not full)
- st_addr  in  32  byte address (ALU result)
- st_data  in  32  unshifted rs2 value
- st_funct3  in  3  000 SB, 001 SH, 010 SW
- ld_valid  in  1  CPU load in progress
- ld_addr  in  32  load byte address
- ld_hazard  out  1  load overlaps a buffered or incoming store word
- mem_req  out  1  write request to data memory
- mem_addr  out  32  word address, bits [1:0]=0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepted current write
- empty  out  1  no entries buffered
- count  out  $clog2(DEPTH)+1  occupied entries
- st_err  out  1  misaligned store pulse (only with STORE_BUF_ALIGN_CHK_EN)

## Operation
- Push: st_valid && st_ready && funct3 ∈ {000,001,010}. Other funct3 values are dropped silently, and count is unchanged.
- Lane formatting:
  - SB: be = 4'b0001 << addr[1:0], data = {4{st_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, data = {2{st_data[15:0]}}.
  - SW: be = 4'b1111, data = st_data.
  - Stored address = {st_addr[31:2], 2'b00}.
- Drain FSM, two states:
  - IDLE: mem_req=0. Moves to REQ when count≠0.
  - REQ: mem_req=1, outputs driven from the head entry.
  - On mem_ack in REQ: pop head. If the post-pop count is 0 (no simultaneous push), go to IDLE; otherwise stay in REQ with the next head.
- Handshake: mem_req/addr/wdata/be are registered and stable until the cycle mem_ack is sampled high. mem_ack while in IDLE is ignored.
- Simultaneous push and pop: count unchanged. A push while full is not possible (st_ready=0). A pop while empty is not possible.
- Pointers wrap modulo DEPTH. Full when count==DEPTH.
- ld_hazard (combinational) = ld_valid && (any valid entry with addr[31:2]==ld_addr[31:2], or a push this cycle to the same word). Byte enables are ignored (word granularity).
- Stores are written to memory strictly in order. There is no merging.

## Timing
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_ready=1, empty=1, count=0, st_err=0, FSM=IDLE, pointers=0.
- Reset asserted mid-transaction: all entries are discarded and mem_req drops asynchronously.
- Latency: a push at edge N (into an empty buffer) gives mem_req=1 after edge N+1.
- Back-to-back drain: an ack at edge N presents the next head after edge N, giving 1 write/cycle throughput with mem_ack held high.
- st_ready and empty are derived from registered count and carry no combinational path from st_valid.
- ld_hazard has a combinational path from ld_addr/ld_valid/st_* only.

## Configuration
- STORE_BUF_ALIGN_CHK_EN defined:
  - SH with addr[0]=1, or SW with addr[1:0]≠0, is not pushed.
  - st_err pulses high for the one cycle following the attempt.
- Undefined:
  - st_err is tied 0.
  - Misaligned SH/SW are force-aligned (low address bits ignored for lane selection, SW be=1111) and pushed.

## Structure
- Shared package:
  - funct3 constants F3_SB/F3_SH/F3_SW.
  - Drain state enum {IDLE, REQ}.
  - Entry struct {addr[31:2], wdata[31:0], be[3:0]}.
- Sub-module store_align: combinational funct3/address → be/wdata/misaligned. Instantiated once on the push path.
- FIFO storage, pointers, and FSM are inline in store_buffer.

## Test plan
- SB addr 0x1003 data 0xAABBCCDD → mem_addr 0x1000, be 1000, wdata 0xDDDDDDDD. mem_req rises the cycle after the push.
- SH addr 0x2002 data 0x12345678 → be 1100, wdata 0x56785678. SW 0x3000 → be 1111, wdata passthrough.
- Push 4 stores with mem_ack=0 → st_ready=0, count=4. A fifth st_valid is not accepted. Ack once → st_ready=1, and the next head appears on the next cycle.
- mem_ack held high while pushing 1/cycle → count stays 1, writes emerge in order with no bubbles.
- Store to 0x4000 pending, load 0x4002 → ld_hazard=1. Load 0x4004 → 0. Same-cycle push+load to the same word → 1.
- rst low while mem_req=1 with 3 entries → mem_req=0 immediately, count=0, empty=1. With STORE_BUF_ALIGN_CHK_EN, SW 0x5002 → st_err pulse, count unchanged.
